// File: rtl/shift_link_pkg.sv
// Types and constants shared by both ends of the serial shift-register link.
package shift_link_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } piso_state_t;

    localparam int SHIFT_LINK_LSB_FIRST = 1;

endpackage

// File: rtl/piso_shift_tx_if.sv
// Load handshake and serial output bundle of the PISO transmitter.
interface piso_shift_tx_if #(
    parameter int WIDTH = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, load_data,
        input  load_ready, sout, sout_valid, busy, done
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, sout, sout_valid, busy, done
    );
endinterface

// File: rtl/piso_bit_counter.sv
// Mod-WIDTH bit position counter for the PISO transmitter; last flags position WIDTH-1.
module piso_bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic last
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] cnt;

    assign last = (cnt == CW'(WIDTH - 1));

    // Clear wins over inc so a new frame always starts at bit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter, LSB first with valid strobe.
// Define PISO_PARITY_EN to append an even-parity bit after the data.
module piso_shift_tx
    import shift_link_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    piso_shift_tx_if.slave bus
);
    piso_state_t      state;
    piso_state_t      next_state;
    logic [WIDTH-1:0] shreg;
    logic             last;
    logic             accept;
    logic             ready_int;
    logic             done_int;
    logic             sout_int;
`ifdef PISO_PARITY_EN
    logic             par;
`endif

    piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .inc   (state == SHIFT),
        .last  (last)
    );

    // Ready is gated by reset so nothing is offered while reset is held.
    assign bus.load_ready = ready_int & ~reset;
    assign accept         = bus.load_valid & bus.load_ready;
    assign bus.done       = done_int & ~reset;
    assign bus.sout       = sout_int;
    assign bus.sout_valid = (state != IDLE);
    assign bus.busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Ready and done live in the final-bit cycle so frames can chain with no gap.
    always_comb begin
        next_state = state;
        ready_int  = 1'b0;
        done_int   = 1'b0;
        sout_int   = 1'b0;
        case (state)
            IDLE: begin
                ready_int = 1'b1;
                if (bus.load_valid) next_state = SHIFT;
            end
            SHIFT: begin
                sout_int = shreg[0];
                if (last) begin
`ifdef PISO_PARITY_EN
                    next_state = PARITY;
`else
                    ready_int  = 1'b1;
                    done_int   = 1'b1;
                    next_state = bus.load_valid ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                sout_int   = par;
                ready_int  = 1'b1;
                done_int   = 1'b1;
                next_state = bus.load_valid ? SHIFT : IDLE;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
`ifdef PISO_PARITY_EN
            par   <= 1'b0;
`endif
        end else if (accept) begin
            shreg <= bus.load_data;
`ifdef PISO_PARITY_EN
            par   <= ^bus.load_data;
`endif
        end else if (state == SHIFT) begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
        end
    end
endmodule

// File: doc/piso_shift_tx.md
# piso_shift_tx

Parallel-in, serial-out shift transmitter, the sending end of the team's serial-in shift register link. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, LSB first, with a qualifying valid strobe. A downstream serial-in register that shifts in at its MSB while `sout_valid` is high holds the original word after the last data bit. With `PISO_PARITY_EN` defined, an even-parity bit is appended after the data.

## Interface
- `WIDTH`, default 4: data word width, at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `load_valid`  in  1  a word is offered on `load_data`.
- `load_ready`  out  1  the block can accept a word this cycle.
- `load_data`  in  WIDTH  parallel word, sampled only on handshake.
- `sout`  out  1  serial data bit.
- `sout_valid`  out  1  `sout` carries a frame bit this cycle.
- `busy`  out  1  a frame is in progress; equals `sout_valid`.
- `done`  out  1  one-cycle pulse on the final bit of a frame.

## Operation
- **State machine states.** `IDLE`, `SHIFT`, and `PARITY`. `PARITY` exists only with `PISO_PARITY_EN`.
- **Registers.** `shreg[WIDTH-1:0]`, bit counter `cnt` (width $clog2(WIDTH)), `par` (1 bit).
- **Handshake.** A word is accepted when `load_valid && load_ready` at a clock edge.
  - On acceptance: `shreg <= load_data`, `cnt <= 0`, `par <= ^load_data`, next state `SHIFT`.
- **`load_ready` timing.** `load_ready` is 1 in `IDLE` and in the final-bit cycle of a frame; otherwise 0.
  - Final-bit cycle without the macro: `SHIFT` with `cnt == WIDTH-1`.
  - Final-bit cycle with the macro: the `PARITY` cycle.
  - This allows back-to-back frames with no gap.
- **`SHIFT` behaviour.**
  - Outputs: `sout = shreg[0]`, `sout_valid = 1`.
  - Each edge: `shreg <= {1'b0, shreg[WIDTH-1:1]}`, `cnt <= cnt + 1`.
- **Leaving `SHIFT` when `cnt == WIDTH-1`:**
  - Without the macro: the next state is `SHIFT` (new frame) if a handshake occurs, else `IDLE`.
  - With the macro: the next state is always `PARITY`.
- **`PARITY` behaviour.** `sout = par`, `sout_valid = 1`. The next state is `SHIFT` on a handshake, else `IDLE`.
- **`IDLE` behaviour.** `sout = 0`, `sout_valid = 0`. `shreg` holds its value.
- **`done`.** `done = 1` exactly in the final-bit cycle.
- **`load_valid` outside ready cycles.** Ignored when `load_ready = 0`. `load_data` is not sampled and the frame in flight is not disturbed.
- **Reset.**
  - Reset values: state `IDLE`, `shreg = 0`, `cnt = 0`, `par = 0`.
  - Outputs under reset: `sout = 0`, `sout_valid = 0`, `busy = 0`, `done = 0`, `load_ready = 0`.
  - Reset during a frame aborts it: no `done`, and the partial frame is discarded.
  - `load_ready` returns to 1 in the first cycle after reset deasserts.
- **Simultaneous reset and handshake.** Reset wins; the word is not accepted.

## Timing
- **Output registering.** `sout` and `sout_valid` are taken directly from flops: `shreg[0]` or `par`, and the state decode. Neither has combinational dependence on inputs.
- **`load_ready` path.** `load_ready` is combinational from state and `cnt` only; it does not depend on `load_valid`.
- **Latency.** For a handshake at edge N:
  - The first bit (`load_data[0]`) appears in cycle N+1.
  - Bit k appears in cycle N+1+k.
- **Frame length.** WIDTH cycles, or WIDTH+1 with parity.
- **Throughput.** One frame per WIDTH (or WIDTH+1) cycles when `load_valid` is held high continuously.

## Configuration
- **`PISO_PARITY_EN` defined.**
  - The `PARITY` state is compiled in and the frame is WIDTH+1 bits.
  - The last bit is even parity: the XOR of all data bits.
  - `done` and `load_ready` move to the parity cycle.
- **`PISO_PARITY_EN` undefined.**
  - No `PARITY` state and no `par` register.
  - The frame is WIDTH bits; `done` and `load_ready` occur in the `cnt == WIDTH-1` cycle.

## Structure
- **Shared package `shift_link_pkg`:**
  - enum typedef `piso_state_t` with `IDLE`, `SHIFT`, `PARITY`.
  - localparam `SHIFT_LINK_LSB_FIRST = 1`, shared with the receiver side.
- **Sub-module.** One is natural: `piso_bit_counter`.
  - Function: a mod-WIDTH counter with `clear`/`inc` inputs and a `last` output (`cnt == WIDTH-1`).
  - Instantiated once.
- **Datapath.** The shift register stays in the top-level module.

## Test plan
- **Single frame.** Reset, then WIDTH=4, load 4'b1011 at edge N → `sout` = 1,1,0,1 in cycles N+1..N+4 with `sout_valid` = 1; `done` only in N+4; `load_ready` = 0 in N+1..N+3.
- **Back-to-back frames.** Hold `load_valid` high with 4'b0110, then 4'b1001 → eight contiguous valid cycles `sout` = 0,1,1,0,1,0,0,1; `done` in cycles 4 and 8; no idle gap.
- **Offer while busy.** Present 4'b1111 with `load_valid` in cycle N+2 of a 4'b0000 frame, then drop it → all four bits 0; 4'b1111 never transmitted.
- **Reset mid-frame.** Assert reset in cycle N+2 → next cycle `sout` = 0, `sout_valid` = 0, no `done`; a fresh load of 4'b0101 then transmits 1,0,1,0.
- **Parity (macro defined).** Load 4'b1011 → `sout` = 1,1,0,1,1 over five cycles; `done` on the fifth. Load 4'b0011 → parity bit 0.
- **Loopback.** Connect `sout`/`sout_valid` to a 4-bit serial-in register shifting at its MSB, send 16 random words → register equals each word in the cycle after its `done`.
